// File: rtl/button_event_ctrl.sv
// Button event controller: turns debounced key levels into an ordered stream of
// press/release/repeat events, buffered in a small show-ahead FIFO.
module button_event_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned REPEAT_DELAY = 500,
  parameter int unsigned REPEAT_RATE  = 100,
  // Derived from WIDTH; leave at its default.
  parameter int unsigned ID_WIDTH     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              keys_in,
  input  logic                          enable,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [ID_WIDTH-1:0]           evt_id,
  output logic [1:0]                    evt_type,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  localparam logic [1:0] EvtPress   = 2'b01;
  localparam logic [1:0] EvtRelease = 2'b10;
  localparam logic [1:0] EvtRepeat  = 2'b11;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDelay = 2'd1;
  localparam logic [1:0] StRate  = 2'd2;

  logic [WIDTH-1:0]    keys_q, keys_d, prev_q, prev_d, chg, edge_mask;
  logic [ID_WIDTH-1:0] edge_idx;
  logic                edge_push, edge_press;

  logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
  logic                tick;

  logic [1:0]          state_q, state_d;
  logic [ID_WIDTH-1:0] rep_key_q, rep_key_d, pend_key_q, pend_key_d;
  logic [RepW-1:0]     rep_cnt_q, rep_cnt_d;
  logic                rep_pend_q, rep_pend_d, rep_push;

  logic [ID_WIDTH-1:0] id_mem_q [FIFO_DEPTH];
  logic [ID_WIDTH-1:0] id_mem_d [FIFO_DEPTH];
  logic [1:0]          type_mem_q [FIFO_DEPTH];
  logic [1:0]          type_mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                push, full, empty, do_wr, do_rd;
  logic [ID_WIDTH-1:0] push_id;
  logic [1:0]          push_type;

  // Edge detection and lowest-index-first arbitration, one edge per cycle.
  always_comb begin
    keys_d     = keys_in;
    chg        = keys_q ^ prev_q;
    edge_mask  = chg & (~chg + WIDTH'(1));
    edge_idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (edge_mask[i]) edge_idx = ID_WIDTH'(i);
    end
    edge_press = |(keys_q & edge_mask);
    edge_push  = enable && (chg != '0);
    // Disabled: resynchronise so changes seen while off never become events.
    prev_d     = enable ? ((prev_q & ~edge_mask) | (keys_q & edge_mask)) : keys_q;
  end

  // Free-running repeat tick prescaler.
  always_comb begin
    tick       = (tick_cnt_q == TickW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
  end

  // Auto-repeat FSM for the most recently pressed key.
  always_comb begin
    state_d    = state_q;
    rep_key_d  = rep_key_q;
    pend_key_d = pend_key_q;
    rep_cnt_d  = rep_cnt_q;
    rep_pend_d = rep_pend_q;
    rep_push   = enable && rep_pend_q && !edge_push;
    if (rep_push) rep_pend_d = 1'b0;
    if (tick) begin
      case (state_q)
        StDelay: begin
          if (rep_cnt_q == RepW'(REPEAT_DELAY - 1)) begin
            rep_pend_d = 1'b1;
            pend_key_d = rep_key_q;
            rep_cnt_d  = '0;
            state_d    = StRate;
          end else begin
            rep_cnt_d = rep_cnt_q + RepW'(1);
          end
        end
        StRate: begin
          if (rep_cnt_q == RepW'(REPEAT_RATE - 1)) begin
            rep_pend_d = 1'b1;
            pend_key_d = rep_key_q;
            rep_cnt_d  = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + RepW'(1);
          end
        end
        default: ;
      endcase
    end
    if (edge_push) begin
      if (edge_press) begin
        if (REPEAT_DELAY != 0) begin
          state_d   = StDelay;
          rep_key_d = edge_idx;
          rep_cnt_d = '0;
        end
        // A repeat already owed to the old key is still delivered after this
        // press; one that would only have matured this cycle is abandoned.
        rep_pend_d = rep_pend_q;
        pend_key_d = pend_key_q;
      end else begin
        if (rep_pend_q && (edge_idx == pend_key_q)) rep_pend_d = 1'b0;
        if ((state_q != StIdle) && (edge_idx == rep_key_q)) begin
          state_d    = StIdle;
          rep_cnt_d  = '0;
          rep_pend_d = 1'b0;
        end
      end
    end
    if (!enable) begin
      state_d    = StIdle;
      rep_cnt_d  = '0;
      rep_pend_d = 1'b0;
    end
  end

  // Event FIFO; fullness is judged before any same-cycle pop.
  always_comb begin
    full       = (count_q == CntW'(FIFO_DEPTH));
    empty      = (count_q == '0);
    push       = edge_push || rep_push;
    push_id    = edge_push ? edge_idx : pend_key_q;
    push_type  = edge_push ? (edge_press ? EvtPress : EvtRelease) : EvtRepeat;
    do_wr      = push && !full;
    do_rd      = evt_ready && !empty;
    id_mem_d   = id_mem_q;
    type_mem_d = type_mem_q;
    if (do_wr) begin
      id_mem_d[wr_ptr_q]   = push_id;
      type_mem_d[wr_ptr_q] = push_type;
    end
    wr_ptr_d   = wr_ptr_q + PtrW'(do_wr);
    rd_ptr_d   = rd_ptr_q + PtrW'(do_rd);
    count_d    = count_q + CntW'(do_wr) - CntW'(do_rd);
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (push && full)   overflow_d = 1'b1;
  end

  // All state registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      keys_q     <= '0;
      prev_q     <= '0;
      tick_cnt_q <= '0;
      state_q    <= StIdle;
      rep_key_q  <= '0;
      pend_key_q <= '0;
      rep_cnt_q  <= '0;
      rep_pend_q <= 1'b0;
      id_mem_q   <= '{default: '0};
      type_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      keys_q     <= keys_d;
      prev_q     <= prev_d;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      rep_key_q  <= rep_key_d;
      pend_key_q <= pend_key_d;
      rep_cnt_q  <= rep_cnt_d;
      rep_pend_q <= rep_pend_d;
      id_mem_q   <= id_mem_d;
      type_mem_q <= type_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid  = !empty;
  assign evt_id     = id_mem_q[rd_ptr_q];
  assign evt_type   = type_mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: expected events are queued as
// stimulus is driven and compared in order as the consumer pops them.
module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] keys_in;
  logic       enable;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       clear_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;
  int n_seen   = 0;
  int seen_cyc [$];
  logic [3:0] exp_q [$];

  button_event_ctrl #(
    .WIDTH       (4),
    .FIFO_DEPTH  (4),
    .TICK_DIV    (4),
    .REPEAT_DELAY(3),
    .REPEAT_RATE (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .keys_in       (keys_in),
    .enable        (enable),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_id        (evt_id),
    .evt_type      (evt_type),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [1:0] id, input logic [1:0] typ);
    exp_q.push_back({id, typ});
  endtask

  task automatic wait_seen(input int target, input string tag);
    int budget = 80;
    while (n_seen < target && budget > 0) begin
      step(1);
      budget--;
    end
    check_eq(tag, 32'(n_seen), 32'(target));
  endtask

  // Consumer side: every accepted head event is compared with the scoreboard.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!reset && evt_valid && evt_ready) begin
      check_eq("evt_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("evt_id", 32'(evt_id), 32'(e[3:2]));
        check_eq("evt_type", 32'(evt_type), 32'(e[1:0]));
      end
      seen_cyc.push_back(cycle);
      n_seen++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int p;
    reset          = 1'b1;
    keys_in        = 4'b0000;
    enable         = 1'b1;
    evt_ready      = 1'b1;
    clear_overflow = 1'b0;
    step(3);
    check_eq("rst_valid", 32'(evt_valid), 32'd0);
    check_eq("rst_id", 32'(evt_id), 32'd0);
    check_eq("rst_type", 32'(evt_type), 32'd0);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    step(2);

    // Single press then release, with latency check.
    base = n_seen;
    expect_evt(2'd2, 2'b01);
    keys_in = 4'b0100;
    step(1);
    check_eq("press_lat_n", 32'(evt_valid), 32'd0);
    step(1);
    check_eq("press_lat_n1", 32'(evt_valid), 32'd1);
    check_eq("press_id", 32'(evt_id), 32'd2);
    check_eq("press_type", 32'(evt_type), 32'd1);
    check_eq("press_count", 32'(fifo_count), 32'd1);
    expect_evt(2'd2, 2'b10);
    keys_in = 4'b0000;
    wait_seen(base + 2, "single_seen");
    step(2);
    check_eq("single_drained", 32'(fifo_count), 32'd0);

    // Simultaneous presses queue lowest index first.
    base = n_seen;
    evt_ready = 1'b0;
    expect_evt(2'd0, 2'b01);
    expect_evt(2'd1, 2'b01);
    expect_evt(2'd3, 2'b01);
    keys_in = 4'b1011;
    step(5);
    check_eq("simul_count", 32'(fifo_count), 32'd3);
    check_eq("simul_head_id", 32'(evt_id), 32'd0);
    expect_evt(2'd0, 2'b10);
    expect_evt(2'd1, 2'b10);
    expect_evt(2'd3, 2'b10);
    evt_ready = 1'b1;
    keys_in   = 4'b0000;
    wait_seen(base + 6, "simul_seen");

    // Auto-repeat on a held key.
    base = n_seen;
    expect_evt(2'd1, 2'b01);
    expect_evt(2'd1, 2'b11);
    expect_evt(2'd1, 2'b11);
    expect_evt(2'd1, 2'b11);
    keys_in = 4'b0010;
    wait_seen(base + 4, "rep_seen");
    p = seen_cyc[base + 1] - seen_cyc[base];
    check_eq("rep_first_window", 32'(p >= 8 && p <= 16), 32'd1);
    check_eq("rep_rate_1", 32'(seen_cyc[base + 2] - seen_cyc[base + 1]), 32'd8);
    check_eq("rep_rate_2", 32'(seen_cyc[base + 3] - seen_cyc[base + 2]), 32'd8);
    expect_evt(2'd1, 2'b10);
    keys_in = 4'b0000;
    wait_seen(base + 5, "rep_release_seen");
    step(30);
    check_eq("rep_stopped", 32'(n_seen), 32'(base + 5));

    // Edge press lands on the cycle a key1 repeat is owed.
    base = n_seen;
    expect_evt(2'd1, 2'b01);
    expect_evt(2'd1, 2'b11);
    keys_in = 4'b0010;
    wait_seen(base + 2, "coll_first_seen");
    p = seen_cyc[base + 1];
    while (cycle < p + 6) step(1);
    expect_evt(2'd2, 2'b01);
    expect_evt(2'd1, 2'b11);
    expect_evt(2'd2, 2'b11);
    keys_in = 4'b0110;
    wait_seen(base + 5, "coll_seen");
    check_eq("coll_press_cyc", 32'(seen_cyc[base + 2] - p), 32'd8);
    check_eq("coll_repeat_cyc", 32'(seen_cyc[base + 3] - p), 32'd9);
    p = seen_cyc[base + 4] - seen_cyc[base + 2];
    check_eq("coll_retarget_window", 32'(p >= 8 && p <= 16), 32'd1);
    expect_evt(2'd1, 2'b10);
    expect_evt(2'd2, 2'b10);
    keys_in = 4'b0000;
    wait_seen(base + 7, "coll_release_seen");
    step(20);
    check_eq("coll_quiet", 32'(n_seen), 32'(base + 7));

    // Overflow: five toggles into a 4-deep FIFO with the consumer stalled.
    base = n_seen;
    evt_ready = 1'b0;
    expect_evt(2'd0, 2'b01);
    expect_evt(2'd0, 2'b10);
    expect_evt(2'd0, 2'b01);
    expect_evt(2'd0, 2'b10);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        check_eq("ovf_full_count", 32'(fifo_count), 32'd4);
        check_eq("ovf_not_yet", 32'(overflow), 32'd0);
      end
      keys_in = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      step(2);
    end
    check_eq("ovf_count", 32'(fifo_count), 32'd4);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    check_eq("ovf_head_type", 32'(evt_type), 32'd1);
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    check_eq("ovf_cleared", 32'(overflow), 32'd0);
    check_eq("ovf_count_kept", 32'(fifo_count), 32'd4);
    expect_evt(2'd0, 2'b10);
    evt_ready = 1'b1;
    keys_in   = 4'b0000;
    wait_seen(base + 5, "ovf_seen");
    check_eq("ovf_stays_clear", 32'(overflow), 32'd0);

    // Reset mid-operation with keys held.
    base = n_seen;
    evt_ready = 1'b0;
    keys_in   = 4'b0011;
    step(4);
    check_eq("prerst_count", 32'(fifo_count), 32'd2);
    reset = 1'b1;
    step(1);
    check_eq("midrst_valid", 32'(evt_valid), 32'd0);
    check_eq("midrst_count", 32'(fifo_count), 32'd0);
    reset     = 1'b0;
    evt_ready = 1'b1;
    expect_evt(2'd0, 2'b01);
    expect_evt(2'd1, 2'b01);
    wait_seen(base + 2, "rst_press_seen");
    expect_evt(2'd0, 2'b10);
    expect_evt(2'd1, 2'b10);
    keys_in = 4'b0000;
    wait_seen(base + 4, "rst_release_seen");

    // Disabled: toggles create nothing, but the FIFO still drains.
    base = n_seen;
    evt_ready = 1'b0;
    expect_evt(2'd3, 2'b01);
    keys_in = 4'b1000;
    step(3);
    check_eq("dis_preload", 32'(fifo_count), 32'd1);
    enable  = 1'b0;
    keys_in = 4'b0000;
    step(2);
    keys_in = 4'b0100;
    step(2);
    keys_in = 4'b0000;
    step(2);
    check_eq("dis_no_push", 32'(fifo_count), 32'd1);
    evt_ready = 1'b1;
    wait_seen(base + 1, "dis_drain_seen");
    step(2);
    enable = 1'b1;
    step(20);
    check_eq("dis_no_events", 32'(n_seen), 32'(base + 1));
    check_eq("dis_empty", 32'(fifo_count), 32'd0);

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
